// File: rtl/wptr_ctrl_lvl.sv
// -----------------------------------------------------------------------------
// wptr_ctrl_lvl -- write-domain pointer controller for an asynchronous FIFO.
//
// Purpose:
//    Keeps the binary/Gray write pointer and synchronizes the Gray read
//    pointer into wclk through a SYNC_STAGES-deep flop chain. From these it
//    produces a registered full flag, a fill level, an almost-full flag and,
//    when enabled, a sticky overflow flag. Every flag describes the state
//    after the write accepted on the same edge. The read pointer is seen
//    with lag, so level and full can overstate occupancy but never
//    understate it.
//
// Parameters:
//    ADDRSIZE     memory address width, DEPTH = 2**ADDRSIZE (>= 2)
//    SYNC_STAGES  flop stages in the read-pointer synchronizer (>= 2)
//
// Ports:
//    wclk          in   write clock
//    wrst_n        in   asynchronous active-low reset
//    winc          in   write request, accepted only while wfull = 0
//    wclr_ovf      in   clear pulse for wovf
//    rptr_async    in   Gray read pointer from the rclk domain (unsynchronized)
//    afull_thresh  in   almost-full threshold in words (quasi-static)
//    waddr         out  memory write address (low bits of binary pointer)
//    wptr          out  registered Gray write pointer to the read domain
//    wfull         out  registered full flag
//    wafull        out  registered almost-full flag (wlevel >= afull_thresh)
//    wlevel        out  registered fill level, 0..DEPTH
//    wovf          out  sticky overflow flag
//
// Build option:
//    WPTR_OVERFLOW_EN  when defined, builds the sticky overflow flop. When
//                      undefined, wovf is tied low and wclr_ovf is ignored.
// -----------------------------------------------------------------------------
module wptr_ctrl_lvl #(
   parameter int ADDRSIZE    = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                wclk,
   input  logic                wrst_n,
   input  logic                winc,
   input  logic                wclr_ovf,
   input  logic [ADDRSIZE:0]   rptr_async,
   input  logic [ADDRSIZE:0]   afull_thresh,
   output logic [ADDRSIZE-1:0] waddr,
   output logic [ADDRSIZE:0]   wptr,
   output logic                wfull,
   output logic                wafull,
   output logic [ADDRSIZE:0]   wlevel,
   output logic                wovf
);

   // ------------------------------------------------------------------
   // Elaboration-time parameter guards
   // ------------------------------------------------------------------
   generate
      if (ADDRSIZE < 2) begin : g_bad_addrsize
         $error("wptr_ctrl_lvl: ADDRSIZE must be >= 2");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync_stages
         $error("wptr_ctrl_lvl: SYNC_STAGES must be >= 2");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Read-pointer synchronizer
   // ------------------------------------------------------------------
   logic [ADDRSIZE:0] sync_q [SYNC_STAGES];
   logic [ADDRSIZE:0] wq_rptr;
   logic [ADDRSIZE:0] rbin_s;

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_q[i] <= '0;
         end
      end else begin
         sync_q[0] <= rptr_async;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_q[i] <= sync_q[i-1];
         end
      end
   end

   assign wq_rptr = sync_q[SYNC_STAGES-1];

   // Gray to binary: each binary bit is the XOR of all Gray bits at or
   // above it. Written as a reduction per bit so there is no ripple chain
   // through a single vector.
   genvar gi;
   generate
      for (gi = 0; gi <= ADDRSIZE; gi++) begin : g_rbin
         assign rbin_s[gi] = ^wq_rptr[ADDRSIZE:gi];
      end
   endgenerate

   // ------------------------------------------------------------------
   // Write pointer, full, level and almost-full
   // ------------------------------------------------------------------
   logic [ADDRSIZE:0] wbin_q,   wbin_d;
   logic [ADDRSIZE:0] wgray_q,  wgray_d;
   logic [ADDRSIZE:0] wlevel_q, wlevel_d;
   logic              wfull_q,  wfull_d;
   logic              wafull_q, wafull_d;
   logic              wen;
   logic [ADDRSIZE:0] rptr_full_pattern;

   assign wen = winc & ~wfull_q;

   // In Gray code, "write pointer exactly DEPTH ahead of read pointer"
   // means the two MSBs differ and every remaining bit matches.
   assign rptr_full_pattern = {~wq_rptr[ADDRSIZE:ADDRSIZE-1],
                               wq_rptr[ADDRSIZE-2:0]};

   always_comb begin
      wbin_d   = wbin_q + {{ADDRSIZE{1'b0}}, wen};
      wgray_d  = (wbin_d >> 1) ^ wbin_d;
      wfull_d  = (wgray_d == rptr_full_pattern);
      // Modulo 2**(ADDRSIZE+1) subtraction. Because writes stop at full,
      // the result always lies in 0..DEPTH.
      wlevel_d = wbin_d - rbin_s;
      wafull_d = (wlevel_d >= afull_thresh);
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wbin_q   <= '0;
         wgray_q  <= '0;
         wlevel_q <= '0;
         wfull_q  <= 1'b0;
         wafull_q <= 1'b0;
      end else begin
         wbin_q   <= wbin_d;
         wgray_q  <= wgray_d;
         wlevel_q <= wlevel_d;
         wfull_q  <= wfull_d;
         wafull_q <= wafull_d;
      end
   end

   assign waddr  = wbin_q[ADDRSIZE-1:0];
   assign wptr   = wgray_q;
   assign wfull  = wfull_q;
   assign wafull = wafull_q;
   assign wlevel = wlevel_q;

   // ------------------------------------------------------------------
   // Sticky overflow
   // ------------------------------------------------------------------
`ifdef WPTR_OVERFLOW_EN
   logic wovf_q, wovf_d;
   logic ovf_set;

   // A request presented while full is dropped and flagged. A new
   // overflow in the same cycle as a clear takes priority, so the event
   // is never lost.
   assign ovf_set = winc & wfull_q;

   always_comb begin
      wovf_d = wovf_q;
      if (ovf_set) begin
         wovf_d = 1'b1;
      end else if (wclr_ovf) begin
         wovf_d = 1'b0;
      end
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         wovf_q <= 1'b0;
      end else begin
         wovf_q <= wovf_d;
      end
   end

   assign wovf = wovf_q;
`else
   logic unused_wclr_ovf;

   assign unused_wclr_ovf = wclr_ovf;
   assign wovf            = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_ctrl_lvl.sv
// -----------------------------------------------------------------------------
// tb_wptr_ctrl_lvl -- self-checking bench for wptr_ctrl_lvl (ADDRSIZE=4,
// SYNC_STAGES=2).
//
// The reference model counts accepted writes and read progress as plain
// integers. Level is the write count minus the read count seen two edges
// earlier, full means level == DEPTH, and almost-full is a plain compare.
// Directed phases (fill, overflow, drain, thresholds, wrap) and a random
// phase are all checked against the model after every edge. Literal
// expectations pin a few points of the model.
// -----------------------------------------------------------------------------
module tb_wptr_ctrl_lvl;

   localparam int AW    = 4;
   localparam int DEPTH = 16;

   logic          wclk = 1'b0;
   logic          wrst_n = 1'b1;
   logic          winc = 1'b0;
   logic          wclr_ovf = 1'b0;
   logic [AW:0]   rptr_async = '0;
   logic [AW:0]   afull_thresh = 5'd12;
   logic [AW-1:0] waddr;
   logic [AW:0]   wptr;
   logic          wfull;
   logic          wafull;
   logic [AW:0]   wlevel;
   logic          wovf;

   wptr_ctrl_lvl #(.ADDRSIZE(AW), .SYNC_STAGES(2)) dut (
      .wclk         (wclk),
      .wrst_n       (wrst_n),
      .winc         (winc),
      .wclr_ovf     (wclr_ovf),
      .rptr_async   (rptr_async),
      .afull_thresh (afull_thresh),
      .waddr        (waddr),
      .wptr         (wptr),
      .wfull        (wfull),
      .wafull       (wafull),
      .wlevel       (wlevel),
      .wovf         (wovf)
   );

   always #5 wclk = ~wclk;

   int checks = 0;
   int errors = 0;

   // model state
   int  m_wcnt;    // total accepted writes since reset
   int  m_h1;      // read count presented one edge ago
   int  m_h2;      // read count presented two edges ago
   int  m_level;
   bit  m_full;
   bit  m_afull;
   bit  m_ovf;
   int  rcnt;      // read count driven onto rptr_async
   logic [AW:0] prev_wptr;
   int  wrap_addr;
   int  wrap_ptr;

   function automatic logic [AW:0] to_gray(input int v);
      logic [AW:0] b;
      b = v[AW:0];
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wcnt = 0; m_h1 = 0; m_h2 = 0; m_level = 0;
      m_full = 0; m_afull = 0; m_ovf = 0;
      prev_wptr = '0;
   endtask

   // One clock edge: advance the model with the inputs present at the
   // edge, then compare every output shortly after the edge.
   task automatic step();
      bit acc;
      bit ovf_set;
      int used;
      @(posedge wclk);
      ovf_set = winc && m_full;
      acc     = winc && !m_full;
      m_wcnt  = m_wcnt + (acc ? 1 : 0);
      used    = m_h2;
      m_h2    = m_h1;
      m_h1    = rcnt;
      m_level = (m_wcnt - used) & 31;
      m_full  = (m_level == DEPTH);
      m_afull = (m_level >= int'(afull_thresh));
`ifdef WPTR_OVERFLOW_EN
      if (ovf_set) m_ovf = 1'b1;
      else if (wclr_ovf) m_ovf = 1'b0;
`else
      m_ovf = ovf_set & 1'b0;
`endif
      #1;
      chk("wptr",   32'(wptr),   32'(to_gray(m_wcnt)));
      chk("waddr",  32'(waddr),  32'(m_wcnt & 15));
      chk("wlevel", 32'(wlevel), 32'(m_level));
      chk("wfull",  32'(wfull),  32'(m_full));
      chk("wafull", 32'(wafull), 32'(m_afull));
      chk("wovf",   32'(wovf),   32'(m_ovf));
      chk("wptr_onebit", 32'($countones(wptr ^ prev_wptr) <= 1), 32'd1);
      if (prev_wptr == 5'b10000 && wptr == 5'b00000) wrap_ptr++;
      prev_wptr = wptr;
   endtask

   // Reset asserted mid-cycle; outputs must clear without a clock edge.
   task automatic do_reset();
      @(posedge wclk);
      #3;
      wrst_n = 1'b0;
      #1;
      chk("rst_waddr",  32'(waddr),  32'd0);
      chk("rst_wptr",   32'(wptr),   32'd0);
      chk("rst_wlevel", 32'(wlevel), 32'd0);
      chk("rst_wfull",  32'(wfull),  32'd0);
      chk("rst_wafull", 32'(wafull), 32'd0);
      chk("rst_wovf",   32'(wovf),   32'd0);
      model_reset();
      rcnt = 0; rptr_async = '0; winc = 1'b0; wclr_ovf = 1'b0;
      repeat (2) @(negedge wclk);
      wrst_n = 1'b1;
   endtask

   initial begin
      model_reset();
      rcnt = 0; wrap_addr = 0; wrap_ptr = 0;
      afull_thresh = 5'd12;
      do_reset();

      // Fill: 16 writes with the read pointer at 0.
      for (int i = 0; i < DEPTH; i++) begin
         winc = 1'b1;
         chk("fill_waddr_pre", 32'(waddr), 32'(i));
         step();
         chk("fill_level", 32'(wlevel), 32'(i + 1));
         chk("fill_afull", 32'(wafull), 32'((i + 1) >= 12));
      end
      chk("fill_wptr", 32'(wptr), 32'h18);
      chk("fill_full", 32'(wfull), 32'd1);
      chk("fill_waddr_wrap", 32'(waddr), 32'd0);

      // Overflow: further writes while full are dropped.
      for (int i = 0; i < 3; i++) begin
         winc = 1'b1;
         step();
      end
      chk("ovf_wptr_hold", 32'(wptr), 32'h18);
`ifdef WPTR_OVERFLOW_EN
      chk("ovf_set", 32'(wovf), 32'd1);
`endif
      winc = 1'b0; wclr_ovf = 1'b1;
      step();
      chk("ovf_clr", 32'(wovf), 32'd0);
      winc = 1'b1; wclr_ovf = 1'b1;
      step();
`ifdef WPTR_OVERFLOW_EN
      chk("ovf_set_wins", 32'(wovf), 32'd1);
`endif
      winc = 1'b0; wclr_ovf = 1'b1;
      step();
      wclr_ovf = 1'b0;

      // Drain release: read pointer advances to 4.
      rcnt = 4; rptr_async = 5'b00110;
      step();
      step();
      chk("drain_full_2", 32'(wfull), 32'd1);
      step();
      chk("drain_full_3", 32'(wfull), 32'd0);
      chk("drain_level", 32'(wlevel), 32'd12);
      chk("drain_afull12", 32'(wafull), 32'd1);

      // Almost-full falls when the level drops to 11.
      rcnt = 5; rptr_async = to_gray(5);
      repeat (3) step();
      chk("afull_fall_level", 32'(wlevel), 32'd11);
      chk("afull_fall", 32'(wafull), 32'd0);

      // Threshold above DEPTH: never asserted, even at full.
      afull_thresh = 5'd17;
      for (int i = 0; i < 20 && !wfull; i++) begin
         winc = 1'b1;
         step();
      end
      chk("thr17_full", 32'(wfull), 32'd1);
      chk("thr17_afull", 32'(wafull), 32'd0);

      // Wrap-around: 40 writes with the read count kept 2 behind.
      afull_thresh = 5'd12;
      for (int i = 0; i < 40; i++) begin
         logic [AW-1:0] a_before;
         if (m_wcnt - 2 > rcnt) rcnt = m_wcnt - 2;
         rptr_async = to_gray(rcnt);
         winc = 1'b1;
         a_before = waddr;
         step();
         if (a_before == 4'd15 && waddr == 4'd0) wrap_addr++;
      end
      chk("wrap_waddr_seen", 32'(wrap_addr > 0), 32'd1);
      chk("wrap_wptr_seen", 32'(wrap_ptr > 0), 32'd1);

      // Random traffic, with one mid-stream reset.
      for (int c = 0; c < 2000; c++) begin
         int inc;
         if (c == 900) begin
            do_reset();
            winc = 1'b1;
            step();
            chk("rst_restart_wptr", 32'(wptr), 32'd1);
         end
         if (c % 200 == 0) afull_thresh = 5'($urandom_range(0, 18));
         winc     = ($urandom_range(0, 9) < 6);
         wclr_ovf = ($urandom_range(0, 9) == 0);
         inc = $urandom_range(0, 2);
         if (rcnt + inc <= m_wcnt) rcnt = rcnt + inc;
         rptr_async = to_gray(rcnt);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
